// File: rtl/stopwatch_counter_pkg.sv
// Shared types and constants for the stopwatch counter slice.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } sw_state_t;

  localparam int DIGIT_MAX_DEC = 9;
  localparam int DIGIT_MAX_SEX = 5;

  // Next value of a BCD digit that wraps to zero after reaching max_val.
  function automatic bcd_t bcd_next(input bcd_t digit, input bcd_t max_val);
    bcd_t result;
    if (digit == max_val) begin
      result = 4'd0;
    end else begin
      result = digit + 4'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/stopwatch_counter_if.sv
// Command/status bundle between the stopwatch counter and its environment.
interface stopwatch_counter_if;
  import stopwatch_pkg::*;

  logic i_basetick;
  logic i_start_stop;
  logic i_clear;
  logic i_lap;

  logic o_timerenb;
  bcd_t o_cs_ones;
  bcd_t o_cs_tens;
  bcd_t o_sec_ones;
  bcd_t o_sec_tens;
  bcd_t o_min_ones;
  bcd_t o_min_tens;
  logic o_running;
  logic o_lap;
  logic o_overflow;

  modport master (
    output i_basetick, i_start_stop, i_clear, i_lap,
    input  o_timerenb, o_cs_ones, o_cs_tens, o_sec_ones, o_sec_tens,
           o_min_ones, o_min_tens, o_running, o_lap, o_overflow
  );

  modport slave (
    input  i_basetick, i_start_stop, i_clear, i_lap,
    output o_timerenb, o_cs_ones, o_cs_tens, o_sec_ones, o_sec_tens,
           o_min_ones, o_min_tens, o_running, o_lap, o_overflow
  );

endinterface

// File: rtl/stopwatch_counter_bcd_digit.sv
// One BCD digit with synchronous clear, increment and carry-out at MODULO_MAX.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MODULO_MAX = DIGIT_MAX_DEC
) (
  input  logic i_sclk,
  input  logic i_reset_n,
  input  logic i_clr,
  input  logic i_inc,
  output bcd_t o_digit,
  output logic o_carry
);

  localparam bcd_t MAX_VAL = bcd_t'(MODULO_MAX);

  bcd_t digit_r;

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      digit_r <= 4'd0;
    end else if (i_clr) begin
      digit_r <= 4'd0;
    end else if (i_inc) begin
      digit_r <= bcd_next(digit_r, MAX_VAL);
    end else begin
      digit_r <= digit_r;
    end
  end

  assign o_digit = digit_r;
  assign o_carry = i_inc & (digit_r == MAX_VAL);

endmodule

// File: rtl/stopwatch_counter.sv
// MM:SS.cc stopwatch: base-tick edge detect, start/pause/clear FSM, lap freeze.
module stopwatch_counter
  import stopwatch_pkg::*;
#(
  parameter int MAX_MIN_TENS = 5
) (
  input  logic               i_sclk,
  input  logic               i_reset_n,
  stopwatch_counter_if.slave bus
);

  sw_state_t   state_r;
  sw_state_t   state_next_s;
  logic        tick_d_r;
  logic        tick_s;
  logic        count_en_s;
  logic        lap_capture_s;
  logic        lap_release_s;
  logic        lap_r;
  logic        running_r;
  logic        timerenb_r;
  logic        overflow_r;
  logic [23:0] hold_r;
  logic [23:0] live_s;
  logic [23:0] display_s;

  bcd_t cs_ones_s, cs_tens_s, sec_ones_s, sec_tens_s, min_ones_s, min_tens_s;
  logic carry0_s, carry1_s, carry2_s, carry3_s, carry4_s, carry5_s;

  assign tick_s = bus.i_basetick & ~tick_d_r;

  // Edge-detect delay runs in every state so resume never sees a stale edge.
  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tick_d_r <= 1'b0;
    end else begin
      tick_d_r <= bus.i_basetick;
    end
  end

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  always_comb begin
    state_next_s = state_r;
    if (bus.i_clear) begin
      state_next_s = IDLE;
    end else if (bus.i_start_stop) begin
      case (state_r)
        IDLE:    state_next_s = RUN;
        RUN:     state_next_s = PAUSE;
        PAUSE:   state_next_s = RUN;
        default: state_next_s = IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Clear beats start/stop beats lap; a lap pulse is dropped if either fires.
  always_comb begin
    count_en_s    = 1'b0;
    lap_capture_s = 1'b0;
    lap_release_s = 1'b0;
    if (bus.i_clear) begin
      count_en_s = 1'b0;
    end else begin
      count_en_s = (state_r == RUN) & tick_s;
      if (bus.i_lap && !bus.i_start_stop) begin
        lap_capture_s = ~lap_r & ((state_r == RUN) | (state_r == PAUSE));
        lap_release_s = lap_r;
      end else begin
        lap_capture_s = 1'b0;
        lap_release_s = 1'b0;
      end
    end
  end

  bcd_digit #(.MODULO_MAX(DIGIT_MAX_DEC)) u_cs_ones (
    .i_sclk(i_sclk), .i_reset_n(i_reset_n), .i_clr(bus.i_clear),
    .i_inc(count_en_s), .o_digit(cs_ones_s), .o_carry(carry0_s));

  bcd_digit #(.MODULO_MAX(DIGIT_MAX_DEC)) u_cs_tens (
    .i_sclk(i_sclk), .i_reset_n(i_reset_n), .i_clr(bus.i_clear),
    .i_inc(carry0_s), .o_digit(cs_tens_s), .o_carry(carry1_s));

  bcd_digit #(.MODULO_MAX(DIGIT_MAX_DEC)) u_sec_ones (
    .i_sclk(i_sclk), .i_reset_n(i_reset_n), .i_clr(bus.i_clear),
    .i_inc(carry1_s), .o_digit(sec_ones_s), .o_carry(carry2_s));

  bcd_digit #(.MODULO_MAX(DIGIT_MAX_SEX)) u_sec_tens (
    .i_sclk(i_sclk), .i_reset_n(i_reset_n), .i_clr(bus.i_clear),
    .i_inc(carry2_s), .o_digit(sec_tens_s), .o_carry(carry3_s));

  bcd_digit #(.MODULO_MAX(DIGIT_MAX_DEC)) u_min_ones (
    .i_sclk(i_sclk), .i_reset_n(i_reset_n), .i_clr(bus.i_clear),
    .i_inc(carry3_s), .o_digit(min_ones_s), .o_carry(carry4_s));

  bcd_digit #(.MODULO_MAX(MAX_MIN_TENS)) u_min_tens (
    .i_sclk(i_sclk), .i_reset_n(i_reset_n), .i_clr(bus.i_clear),
    .i_inc(carry4_s), .o_digit(min_tens_s), .o_carry(carry5_s));

  assign live_s = {min_tens_s, min_ones_s, sec_tens_s, sec_ones_s, cs_tens_s, cs_ones_s};

  always_ff @(posedge i_sclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      running_r  <= 1'b0;
      timerenb_r <= 1'b0;
      lap_r      <= 1'b0;
      hold_r     <= 24'h000000;
      overflow_r <= 1'b0;
    end else begin
      running_r  <= (state_next_s == RUN);
      timerenb_r <= (state_next_s == RUN);
      if (bus.i_clear) begin
        lap_r <= 1'b0;
      end else if (lap_capture_s) begin
        lap_r <= 1'b1;
      end else if (lap_release_s) begin
        lap_r <= 1'b0;
      end else begin
        lap_r <= lap_r;
      end
      if (lap_capture_s) begin
        hold_r <= live_s;
      end else begin
        hold_r <= hold_r;
      end
      if (bus.i_clear) begin
        overflow_r <= 1'b0;
      end else if (carry5_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign display_s = lap_r ? hold_r : live_s;

  assign bus.o_cs_ones  = display_s[3:0];
  assign bus.o_cs_tens  = display_s[7:4];
  assign bus.o_sec_ones = display_s[11:8];
  assign bus.o_sec_tens = display_s[15:12];
  assign bus.o_min_ones = display_s[19:16];
  assign bus.o_min_tens = display_s[23:20];
  assign bus.o_timerenb = timerenb_r;
  assign bus.o_running  = running_r;
  assign bus.o_lap      = lap_r;
  assign bus.o_overflow = overflow_r;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed table plus hand sequences for the stopwatch counter.
module tb_stopwatch_counter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  stopwatch_counter_if bus ();

  stopwatch_counter #(.MAX_MIN_TENS(5)) dut (
    .i_sclk   (clk),
    .i_reset_n(rst_n),
    .bus      (bus)
  );

  typedef struct {
    string       name;
    logic        ss;
    logic        clr;
    logic        lap;
    int          nticks;
    logic [23:0] disp;
    logic        run;
    logic        lap_o;
    logic        ovf;
  } vec_t;

  vec_t vecs[14];

  logic [23:0] disp;
  assign disp = {bus.o_min_tens, bus.o_min_ones, bus.o_sec_tens,
                 bus.o_sec_ones, bus.o_cs_tens, bus.o_cs_ones};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cmd(input logic ss, input logic clr, input logic lap);
    bus.i_start_stop = ss;
    bus.i_clear      = clr;
    bus.i_lap        = lap;
    step();
    bus.i_start_stop = 1'b0;
    bus.i_clear      = 1'b0;
    bus.i_lap        = 1'b0;
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      bus.i_basetick = 1'b1;
      step();
      bus.i_basetick = 1'b0;
      step();
    end
  endtask

  task automatic chk_all(input string name, input logic [23:0] d, input logic run,
                         input logic lp, input logic ovf);
    chk({name, "_disp"}, {8'h00, disp}, {8'h00, d});
    chk({name, "_run"}, {31'd0, bus.o_running}, {31'd0, run});
    chk({name, "_timerenb"}, {31'd0, bus.o_timerenb}, {31'd0, run});
    chk({name, "_lap"}, {31'd0, bus.o_lap}, {31'd0, lp});
    chk({name, "_ovf"}, {31'd0, bus.o_overflow}, {31'd0, ovf});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0]  = '{"idle_ticks",       1'b0, 1'b0, 1'b0, 3,    24'h000000, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{"start_1tick",      1'b1, 1'b0, 1'b0, 1,    24'h000001, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{"to_1s",            1'b0, 1'b0, 1'b0, 99,   24'h000100, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{"to_1min",          1'b0, 1'b0, 1'b0, 5900, 24'h010000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"pause_ticks",      1'b1, 1'b0, 1'b0, 7,    24'h010000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{"resume",           1'b1, 1'b0, 1'b0, 0,    24'h010000, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{"five_more",        1'b0, 1'b0, 1'b0, 5,    24'h010005, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{"lap_freeze",       1'b0, 1'b0, 1'b1, 10,   24'h010005, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{"lap_release",      1'b0, 1'b0, 1'b1, 0,    24'h010015, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{"lap_again",        1'b0, 1'b0, 1'b1, 3,    24'h010015, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{"pause_lapped",     1'b1, 1'b0, 1'b0, 0,    24'h010015, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{"lap_release_pause",1'b0, 1'b0, 1'b1, 0,    24'h010018, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"clear",            1'b0, 1'b1, 1'b0, 0,    24'h000000, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{"lap_idle",         1'b0, 1'b0, 1'b1, 2,    24'h000000, 1'b0, 1'b0, 1'b0};

    rst_n            = 1'b0;
    bus.i_basetick   = 1'b0;
    bus.i_start_stop = 1'b0;
    bus.i_clear      = 1'b0;
    bus.i_lap        = 1'b0;
    step();
    step();
    chk_all("reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 14; i++) begin
      cmd(vecs[i].ss, vecs[i].clr, vecs[i].lap);
      tick(vecs[i].nticks);
      chk_all(vecs[i].name, vecs[i].disp, vecs[i].run, vecs[i].lap_o, vecs[i].ovf);
    end

    // Count becomes visible right after the rising-edge clock; level and fall do nothing.
    cmd(1'b1, 1'b0, 1'b0);
    bus.i_basetick = 1'b1;
    chk("latency_before", {8'h00, disp}, 32'h00000000);
    @(posedge clk);
    #1;
    chk("latency_after", {8'h00, disp}, 32'h00000001);
    step();
    step();
    step();
    chk("level_no_count", {8'h00, disp}, 32'h00000001);
    bus.i_basetick = 1'b0;
    step();
    step();
    chk("falling_edge", {8'h00, disp}, 32'h00000001);

    bus.i_basetick = 1'b1;
    bus.i_clear    = 1'b1;
    step();
    bus.i_basetick = 1'b0;
    bus.i_clear    = 1'b0;
    step();
    chk_all("clear_with_tick", 24'h000000, 1'b0, 1'b0, 1'b0);

    cmd(1'b1, 1'b0, 1'b0);
    tick(2);
    cmd(1'b0, 1'b0, 1'b1);
    chk_all("pre_simul_lap", 24'h000002, 1'b1, 1'b1, 1'b0);
    cmd(1'b1, 1'b1, 1'b1);
    chk_all("simul_cmds", 24'h000000, 1'b0, 1'b0, 1'b0);
    cmd(1'b0, 1'b0, 1'b1);
    chk("simul_is_idle", {31'd0, bus.o_lap}, 32'd0);

    cmd(1'b1, 1'b0, 1'b0);
    cmd(1'b1, 1'b0, 1'b0);
    force dut.u_cs_ones.digit_r  = 4'd9;
    force dut.u_cs_tens.digit_r  = 4'd9;
    force dut.u_sec_ones.digit_r = 4'd9;
    force dut.u_sec_tens.digit_r = 4'd5;
    force dut.u_min_ones.digit_r = 4'd9;
    force dut.u_min_tens.digit_r = 4'd5;
    step();
    release dut.u_cs_ones.digit_r;
    release dut.u_cs_tens.digit_r;
    release dut.u_sec_ones.digit_r;
    release dut.u_sec_tens.digit_r;
    release dut.u_min_ones.digit_r;
    release dut.u_min_tens.digit_r;
    cmd(1'b1, 1'b0, 1'b0);
    chk_all("preload", 24'h595999, 1'b1, 1'b0, 1'b0);
    tick(1);
    chk_all("wrap", 24'h000000, 1'b1, 1'b0, 1'b1);
    tick(1);
    chk_all("ovf_sticky", 24'h000001, 1'b1, 1'b0, 1'b1);
    cmd(1'b0, 1'b1, 1'b0);
    chk_all("ovf_clear", 24'h000000, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-count with the base tick held high across release.
    cmd(1'b1, 1'b0, 1'b0);
    tick(3);
    chk("pre_reset", {8'h00, disp}, 32'h00000003);
    bus.i_basetick = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_reset", 24'h000000, 1'b0, 1'b0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    cmd(1'b1, 1'b0, 1'b0);
    step();
    step();
    step();
    chk_all("no_tick_after_reset", 24'h000000, 1'b1, 1'b0, 1'b0);
    bus.i_basetick = 1'b0;
    step();
    tick(1);
    chk_all("first_tick_after_reset", 24'h000001, 1'b1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
